// File: rtl/seg7_scan_if.sv
// seg7_scan_if: CPU store port and display pins of the 7-segment scan controller
interface seg7_scan_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        enable;
  logic [31:0] rd_data;
  logic        update_pending;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        frame_done;
  modport master (output wr_en, wr_data, wr_be, enable, input rd_data, update_pending, an_n, seg_n, frame_done);
  modport slave (input wr_en, wr_data, wr_be, enable, output rd_data, update_pending, an_n, seg_n, frame_done);
endinterface

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: tear-free 8-digit 7-segment scanner; SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros
module seg7_scan_controller #(
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 16
) (
  input logic         clk,
  input logic         reset,
  seg7_scan_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  localparam logic [31:0] P_LD = 32'(PRESCALE - 1);
  localparam logic [31:0] G_LD = 32'(GAP_CYCLES - 1);
  state_t      state, nstate;
  logic [2:0]  idx, nidx, msd;
  logic [31:0] cnt, ncnt, pending_reg, display_reg, ndisp;
  logic [7:0]  an_r;
  logic [6:0]  seg_r;
  logic        up_r, fd_r, frame_edge, commit, blank;
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction
  // Scan sequencing: dropping enable always wins, otherwise count down the ON/GAP periods
  always_comb begin
    nstate = state;
    nidx = idx;
    ncnt = cnt;
    if (!bus.enable) begin
      nstate = IDLE;
      nidx = 3'd0;
      ncnt = '0;
    end else if (state == IDLE) begin
      nstate = ON;
      nidx = 3'd0;
      ncnt = P_LD;
    end else if (cnt != 0) begin
      ncnt = cnt - 32'd1;
    end else if (state == ON && GAP_CYCLES != 0) begin
      nstate = GAP;
      ncnt = G_LD;
    end else begin
      nstate = ON;
      nidx = idx + 3'd1;
      ncnt = P_LD;
    end
  end
  // The frame ends when digit 7's last period (GAP, or ON without gaps) expires
  assign frame_edge = bus.enable && state != IDLE && cnt == 0 && idx == 3'd7 && (state == GAP || GAP_CYCLES == 0);
  assign commit = frame_edge || (state == IDLE && up_r);
  assign ndisp = commit ? pending_reg : display_reg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Most significant nonzero nibble; digit 0 counts as significant even when zero
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) msd = (ndisp[4*i +: 4] != 4'h0) ? 3'(i) : msd;
  end
  assign blank = nidx > msd;
`else
  assign msd = 3'd0;
  assign blank = 1'b0;
`endif
  // State, store port, commit and registered display pins all move on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= '0;
      pending_reg <= '0;
      display_reg <= '0;
      up_r <= 1'b0;
      fd_r <= 1'b0;
      an_r <= 8'hFF;
      seg_r <= 7'h7F;
    end else begin
      state <= nstate;
      idx <= nidx;
      cnt <= ncnt;
      for (int i = 0; i < 4; i++)
        if (bus.wr_en && bus.wr_be[i]) pending_reg[8*i +: 8] <= bus.wr_data[8*i +: 8];
      up_r <= bus.wr_en || (up_r && !commit);
      display_reg <= ndisp;
      fd_r <= frame_edge;
      an_r <= (nstate == ON) ? ~(8'd1 << nidx) : 8'hFF;
      seg_r <= (nstate == ON && !blank) ? decode(ndisp[{nidx, 2'b00} +: 4]) : 7'h7F;
    end
  end
  assign bus.rd_data = display_reg;
  assign bus.update_pending = up_r;
  assign bus.an_n = an_r;
  assign bus.seg_n = seg_r;
  assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed checks of scan timing, commit rules, enable and reset
module tb_seg7_scan_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] exp_hi;
  seg7_scan_if bus();
  seg7_scan_controller #(.PRESCALE(4), .GAP_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pins(input string tag, input logic [7:0] an, input logic [6:0] seg);
    chk({tag, " an_n"}, {24'd0, bus.an_n}, {24'd0, an});
    chk({tag, " seg_n"}, {25'd0, bus.seg_n}, {25'd0, seg});
  endtask
  initial begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    exp_hi = 7'h7F;
`else
    exp_hi = 7'b1000000;
`endif
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.wr_be = '0;
    bus.enable = 1'b0;
    step();
    step();
    pins("reset", 8'hFF, 7'h7F);
    chk("reset rd_data", bus.rd_data, 32'h0);
    chk("reset update_pending", {31'd0, bus.update_pending}, 32'd0);
    chk("reset frame_done", {31'd0, bus.frame_done}, 32'd0);
    reset = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 32'h12345678;
    bus.wr_be = 4'hF;
    step();
    bus.wr_en = 1'b0;
    chk("write pending", {31'd0, bus.update_pending}, 32'd1);
    chk("write rd before commit", bus.rd_data, 32'h0);
    step();
    chk("idle commit rd", bus.rd_data, 32'h12345678);
    chk("idle commit pending", {31'd0, bus.update_pending}, 32'd0);
    bus.enable = 1'b1;
    step();
    pins("t0 digit0", 8'hFE, 7'b0000000);
    chk("t0 frame_done", {31'd0, bus.frame_done}, 32'd0);
    repeat (3) begin step(); pins("digit0 on", 8'hFE, 7'b0000000); end
    repeat (2) begin step(); pins("gap0", 8'hFF, 7'h7F); end
    repeat (4) begin step(); pins("digit1 on", 8'hFD, 7'b1111000); end
    repeat (10) begin step(); chk("frame_done low", {31'd0, bus.frame_done}, 32'd0); end
    bus.wr_en = 1'b1;
    bus.wr_data = 32'h000000AB;
    bus.wr_be = 4'b0001;
    step();
    bus.wr_en = 1'b0;
    chk("t20 pending", {31'd0, bus.update_pending}, 32'd1);
    chk("t20 rd held", bus.rd_data, 32'h12345678);
    chk("t20 an digit3", {24'd0, bus.an_n}, 32'hF7);
    repeat (27) begin
      step();
      chk("mid-frame rd held", bus.rd_data, 32'h12345678);
      chk("mid-frame frame_done low", {31'd0, bus.frame_done}, 32'd0);
    end
    step();
    chk("t48 frame_done", {31'd0, bus.frame_done}, 32'd1);
    chk("t48 rd committed", bus.rd_data, 32'h123456AB);
    chk("t48 pending clear", {31'd0, bus.update_pending}, 32'd0);
    chk("t48 an", {24'd0, bus.an_n}, 32'hFE);
    step();
    chk("t49 frame_done", {31'd0, bus.frame_done}, 32'd0);
    pins("t49 digit0 B", 8'hFE, 7'b0000011);
    repeat (10) step();
    bus.wr_en = 1'b1;
    bus.wr_data = 32'h0;
    bus.wr_be = 4'hF;
    step();
    bus.wr_en = 1'b0;
    chk("t60 pending", {31'd0, bus.update_pending}, 32'd1);
    repeat (35) step();
    bus.wr_en = 1'b1;
    bus.wr_data = 32'hFFFFFFFF;
    step();
    bus.wr_en = 1'b0;
    chk("t96 frame_done", {31'd0, bus.frame_done}, 32'd1);
    chk("t96 collide rd", bus.rd_data, 32'h0);
    chk("t96 collide pending", {31'd0, bus.update_pending}, 32'd1);
    step();
    chk("t97 rd", bus.rd_data, 32'h0);
    pins("t97 digit0 zero", 8'hFE, 7'b1000000);
    repeat (46) step();
    step();
    chk("t144 frame_done", {31'd0, bus.frame_done}, 32'd1);
    chk("t144 rd", bus.rd_data, 32'hFFFFFFFF);
    chk("t144 pending", {31'd0, bus.update_pending}, 32'd0);
    repeat (19) step();
    chk("t163 an digit3", {24'd0, bus.an_n}, 32'hF7);
    bus.enable = 1'b0;
    step();
    pins("disable dark", 8'hFF, 7'h7F);
    chk("disable frame_done", {31'd0, bus.frame_done}, 32'd0);
    repeat (60) begin
      step();
      chk("idle frame_done low", {31'd0, bus.frame_done}, 32'd0);
      chk("idle an dark", {24'd0, bus.an_n}, 32'hFF);
    end
    bus.enable = 1'b1;
    step();
    pins("restart digit0", 8'hFE, 7'b0001110);
    bus.enable = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 32'h00000050;
    step();
    bus.wr_en = 1'b0;
    step();
    chk("lz rd", bus.rd_data, 32'h00000050);
    chk("lz pending", {31'd0, bus.update_pending}, 32'd0);
    bus.enable = 1'b1;
    step();
    pins("lz digit0", 8'hFE, 7'b1000000);
    repeat (6) step();
    pins("lz digit1", 8'hFD, 7'b0010010);
    repeat (6) step();
    pins("lz digit2", 8'hFB, exp_hi);
    repeat (30) step();
    pins("lz digit7", 8'h7F, exp_hi);
    bus.wr_en = 1'b1;
    bus.wr_data = 32'h0000000A;
    step();
    bus.wr_en = 1'b0;
    chk("pre-reset pending", {31'd0, bus.update_pending}, 32'd1);
    reset = 1'b1;
    step();
    pins("midscan reset", 8'hFF, 7'h7F);
    chk("midscan reset rd", bus.rd_data, 32'h0);
    chk("midscan reset pending", {31'd0, bus.update_pending}, 32'd0);
    chk("midscan reset frame_done", {31'd0, bus.frame_done}, 32'd0);
    step();
    reset = 1'b0;
    bus.enable = 1'b0;
    step();
    step();
    chk("post-reset rd discarded", bus.rd_data, 32'h0);
    chk("post-reset pending", {31'd0, bus.update_pending}, 32'd0);
    pins("post-reset dark", 8'hFF, 7'h7F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
